keypad_event_fifo: RTL and testbench

- Sits between the 4x4 keypad scanner and the MCU input port.
- Debounces the scanner's raw key code and emits exactly one event per physical key press.
- Buffers events in a small FIFO so that keystrokes arriving while the MCU is busy are not lost.
- The MCU reads events through a first-word-fall-through port with a one-cycle pop strobe.

---
 rtl/keypad_event_fifo_if.sv | 33 +++
 rtl/keypad_event_fifo.sv | 121 ++++++++++++
 tb/tb_keypad_event_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_event_fifo_if.sv
// keypad_event_fifo_if: keypad-side inputs, MCU-side FIFO read port and status.
// Carries irq only when KEY_IRQ_EN is defined.
interface keypad_event_fifo_if #(
  parameter int DEPTH = 8
);
  logic                         sample_en;
  logic [3:0]                   kb_code;
  logic                         kb_down;
  logic                         rd_en;
  logic                         clr_ovf;
  logic [7:0]                   rd_data;
  logic                         empty;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;
`ifdef KEY_IRQ_EN
  logic                         irq;
`endif
  modport slave (
    input  sample_en, kb_code, kb_down, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
`ifdef KEY_IRQ_EN
    , irq
`endif
  );
  modport master (
    output sample_en, kb_code, kb_down, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
`ifdef KEY_IRQ_EN
    , irq
`endif
  );
endinterface

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: debounces scanner key codes into one event per press and queues them in a FWFT FIFO.
// Define KEY_IRQ_EN to add a registered irq output that is high while events are pending.
module keypad_event_fifo #(
  parameter int DEPTH            = 8,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input logic                clk,
  input logic                rst,
  keypad_event_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] RELEASING = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          push_q, push_d;
  logic          at_limit;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, overflow_q;
  logic          do_push, do_pop, drop;

  assign cnt_inc  = cnt_q + 1'b1;
  assign at_limit = cnt_inc == NW'(DEBOUNCE_SAMPLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push_d  = 1'b0;
    if (bus.sample_en) begin
      case (state_q)
        IDLE: if (bus.kb_down) begin
          cand_d  = bus.kb_code;
          cnt_d   = NW'(1);
          state_d = ARMING;
        end
        ARMING: if (!bus.kb_down) begin
          state_d = IDLE;
        end else if (bus.kb_code != cand_q) begin
          cand_d = bus.kb_code;
          cnt_d  = NW'(1);
        end else begin
          cnt_d   = cnt_inc;
          push_d  = at_limit;
          state_d = at_limit ? HELD : ARMING;
        end
        // A code change while held is ignored; only a full release re-arms.
        HELD: if (!bus.kb_down) begin
          cnt_d   = NW'(1);
          state_d = RELEASING;
        end
        RELEASING: if (bus.kb_down) begin
          state_d = HELD;
        end else begin
          cnt_d   = cnt_inc;
          state_d = at_limit ? IDLE : RELEASING;
        end
      endcase
    end
  end

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign do_pop  = bus.rd_en & ~empty_q;
  assign do_push = push_q & (~full_q | do_pop);
  assign drop    = push_q & full_q & ~do_pop;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      push_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      push_q     <= push_d;
      wptr_q     <= wptr_q + AW'(do_push);
      rptr_q     <= rptr_q + AW'(do_pop);
      count_q    <= count_d;
      empty_q    <= count_d == '0;
      full_q     <= count_d == CW'(DEPTH);
      overflow_q <= drop | (overflow_q & ~bus.clr_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= cand_q;
  end

  assign bus.rd_data  = empty_q ? 8'h00 : {4'h0, mem_q[rptr_q]};
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef KEY_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else irq_q <= ~empty_q;
  end
  assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_keypad_event_fifo.sv
// tb_keypad_event_fifo: directed scenarios for debounce, FIFO ordering, overflow and reset.
// Build with KEY_IRQ_EN defined to also exercise the irq output.
module tb_keypad_event_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  keypad_event_fifo_if #(.DEPTH(8)) bus ();
  keypad_event_fifo #(.DEPTH(8), .DEBOUNCE_SAMPLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick(input logic d, input logic [3:0] c);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.kb_down   = d;
    bus.kb_code   = c;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic hold(input logic d, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) tick(d, c);
  endtask

  task automatic press_down(input logic [3:0] c);
    hold(1'b1, c, 4);
  endtask

  task automatic release_key();
    hold(1'b0, 4'h0, 4);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %02h want 00", bus.rd_data); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus.overflow); end
`ifdef KEY_IRQ_EN
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", bus.irq); end
`endif
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_clean_press();
    hold(1'b1, 4'h7, 3);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL clean_3ticks_count got %0d want 0", bus.count); end
    tick(1'b1, 4'h7);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL clean_not_yet_visible got %0b want 1", bus.empty); end
    idle(1);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL clean_count got %0d want 1", bus.count); end
    checks++; if (bus.rd_data !== 8'h07) begin errors++; $display("FAIL clean_rd_data got %02h want 07", bus.rd_data); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL clean_empty got %0b want 0", bus.empty); end
    hold(1'b1, 4'h7, 2);
    hold(1'b0, 4'h0, 5);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL clean_single_event got %0d want 1", bus.count); end
    pop();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL clean_pop_empty got %0b want 1", bus.empty); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL clean_pop_rd_data got %02h want 00", bus.rd_data); end
  endtask

  task automatic test_bounce();
    tick(1'b1, 4'h3); tick(1'b0, 4'h3); tick(1'b1, 4'h3); tick(1'b0, 4'h3);
    hold(1'b1, 4'h3, 3);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL bounce_early got %0d want 0", bus.count); end
    tick(1'b1, 4'h3);
    idle(1);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL bounce_count got %0d want 1", bus.count); end
    checks++; if (bus.rd_data !== 8'h03) begin errors++; $display("FAIL bounce_rd_data got %02h want 03", bus.rd_data); end
    tick(1'b1, 4'h5);
    tick(1'b0, 4'h0); tick(1'b0, 4'h0); tick(1'b1, 4'h5);
    release_key();
    idle(2);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL bounce_release_count got %0d want 1", bus.count); end
    checks++; if (bus.rd_data !== 8'h03) begin errors++; $display("FAIL bounce_release_head got %02h want 03", bus.rd_data); end
    pop();
    hold(1'b1, 4'h2, 2);
    hold(1'b1, 4'h9, 3);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL restart_early got %0d want 0", bus.count); end
    tick(1'b1, 4'h9);
    idle(1);
    checks++; if (bus.rd_data !== 8'h09) begin errors++; $display("FAIL restart_rd_data got %02h want 09", bus.rd_data); end
    release_key();
    pop();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      press_down(4'(i));
      release_key();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %0b want 0", bus.overflow); end
    press_down(4'h8);
    release_key();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", bus.overflow); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", bus.count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] got %02h want %02h", i, bus.rd_data, 8'(i)); end
      pop();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", bus.empty); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", bus.overflow); end
    @(negedge clk); bus.clr_ovf = 1'b1;
    @(negedge clk); bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", bus.overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      press_down(4'(8 + i));
      release_key();
    end
    press_down(4'hA);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL simul_count got %0d want 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got %0b want 0", bus.overflow); end
    checks++; if (bus.rd_data !== 8'h09) begin errors++; $display("FAIL simul_head got %02h want 09", bus.rd_data); end
    release_key();
    press_down(4'hB);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL set_wins got %0b want 1", bus.overflow); end
    release_key();
    @(negedge clk); bus.clr_ovf = 1'b1;
    @(negedge clk); bus.clr_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'(9 + i) : 8'h0A;
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simul_order[%0d] got %02h want %02h", i, bus.rd_data, exp); end
      pop();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_drain got %0b want 1", bus.empty); end
  endtask

  task automatic test_empty_pop_reset();
    pop();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL empty_pop_count got %0d want 0", bus.count); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL empty_pop_rd_data got %02h want 00", bus.rd_data); end
    for (int i = 1; i <= 3; i++) begin
      press_down(4'(i));
      release_key();
    end
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL pre_reset_count got %0d want 3", bus.count); end
    hold(1'b1, 4'h5, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", bus.count); end
    @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 4'h5, 2);
    idle(2);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL post_reset_no_event got %0b want 1", bus.empty); end
    release_key();
  endtask

`ifdef KEY_IRQ_EN
  task automatic test_irq();
    press_down(4'h4);
    idle(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %0b want 0", bus.irq); end
    idle(1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set got %0b want 1", bus.irq); end
    release_key();
    pop();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %0b want 1", bus.irq); end
    idle(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %0b want 0", bus.irq); end
  endtask
`endif

  initial begin
    bus.sample_en = 1'b0;
    bus.kb_code   = 4'h0;
    bus.kb_down   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr_ovf   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_fill_overflow();
    test_simultaneous();
    test_empty_pop_reset();
`ifdef KEY_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
